// File: rtl/spi_shift_ctrl.sv
// spi_shift_ctrl: SPI master transfer FSM driving a baud generator, with SS_n setup/hold framing
module spi_shift_ctrl #(
  parameter int DATA_W = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        mode,
  input  logic              strobe,
  input  logic              rise,
  input  logic              fall,
  input  logic              miso,
  output logic              gen_en,
  output logic              sclk_en,
  output logic              mosi,
  output logic              ss_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);
  localparam int CW = $clog2(2 * DATA_W);
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic [CW-1:0] edge_cnt;
  logic cpha, sclk_edge, last_edge, shift_tx, sample_rx, accept, finish;
  logic unused_cpol;
  assign unused_cpol = mode[1];
  assign sclk_edge = state == XFER && (rise || fall);
  assign last_edge = sclk_edge && edge_cnt == CW'(2 * DATA_W - 1);
  // with CPHA=1 the first bit is already on mosi before the first leading edge
  assign shift_tx  = state == XFER && (cpha ? rise && edge_cnt != '0 : fall);
  assign sample_rx = state == XFER && (cpha ? fall : rise);
  assign accept    = state == IDLE && start;
  assign finish    = state == HOLD && strobe;
  assign busy      = state != IDLE;
  assign mosi      = state == IDLE ? 1'b0 : (LSB_FIRST ? tx_sr[0] : tx_sr[DATA_W-1]);
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (start  ? SETUP : IDLE)
             : state == SETUP ? (strobe ? XFER  : SETUP)
             : state == XFER  ? (last_edge ? HOLD : XFER)
             : (strobe ? IDLE : HOLD);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      cpha     <= 1'b0;
      edge_cnt <= '0;
      ss_n     <= 1'b1;
      gen_en   <= 1'b0;
      sclk_en  <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        tx_sr    <= tx_data;
        cpha     <= mode[0];
        rx_sr    <= '0;
        edge_cnt <= '0;
        ss_n     <= 1'b0;
        gen_en   <= 1'b1;
      end
      if (state == SETUP && strobe) sclk_en <= 1'b1;
      if (sclk_edge) edge_cnt <= edge_cnt + 1'b1;
      if (shift_tx) tx_sr <= LSB_FIRST ? tx_sr >> 1 : tx_sr << 1;
      if (sample_rx) rx_sr <= LSB_FIRST ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
      if (last_edge) sclk_en <= 1'b0;
      if (finish) begin
        ss_n    <= 1'b1;
        gen_en  <= 1'b0;
        rx_data <= rx_sr;
      end
    end
endmodule

// File: tb/tb_spi_shift_ctrl.sv
// tb_spi_shift_ctrl: directed vectors against a behavioural baud generator and SPI slave
module tb_spi_shift_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] start = '0, strobe, rise, fall, miso, gen_en, sclk_en, mosi, ss_n, busy, done;
  logic [W-1:0] rx_d [2];
  logic [W-1:0] tx_data = '0, slave = '0, mlog, expm;
  logic [1:0] mode = '0;
  int per = 4, act = 0, k = 0;
  int cnt [2];
  logic ph [2];
  bit loop = 1'b1, cpha_m = 1'b0, prev_ss = 1'b1;
  int cyc = 0, ndone = 0, ss_low = 0, nstb = 0, nedge = 0, nsamp = 0;
  int first_edge = -1, setup_cyc = -1, last_edge = 0, last_stb = 0;
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  spi_shift_ctrl #(.DATA_W(W), .LSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .tx_data(tx_data), .mode(mode), .strobe(strobe[0]),
    .rise(rise[0]), .fall(fall[0]), .miso(miso[0]), .gen_en(gen_en[0]), .sclk_en(sclk_en[0]),
    .mosi(mosi[0]), .ss_n(ss_n[0]), .busy(busy[0]), .done(done[0]), .rx_data(rx_d[0]));
  spi_shift_ctrl #(.DATA_W(W), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .tx_data(tx_data), .mode(mode), .strobe(strobe[1]),
    .rise(rise[1]), .fall(fall[1]), .miso(miso[1]), .gen_en(gen_en[1]), .sclk_en(sclk_en[1]),
    .mosi(mosi[1]), .ss_n(ss_n[1]), .busy(busy[1]), .done(done[1]), .rx_data(rx_d[1]));
  for (genvar g = 0; g < 2; g++) begin : gen_m
    assign strobe[g] = gen_en[g] && cnt[g] == per - 1;
    assign rise[g]   = strobe[g] && sclk_en[g] && !ph[g];
    assign fall[g]   = strobe[g] && sclk_en[g] && ph[g];
    assign miso[g]   = loop ? mosi[g] : (k < W ? slave[g == 1 ? k : W - 1 - k] : 1'b0);
    always @(posedge clk)
      if (!gen_en[g]) begin
        cnt[g] <= 0;
        ph[g]  <= 1'b0;
      end else begin
        cnt[g] <= cnt[g] == per - 1 ? 0 : cnt[g] + 1;
        if (!sclk_en[g]) ph[g] <= 1'b0;
        else if (strobe[g]) ph[g] <= ~ph[g];
      end
  end
  always @(posedge clk)
    if (ss_n[act]) k <= 0;
    else if (cpha_m ? fall[act] : rise[act]) k <= k + 1;
  always @(negedge clk) begin
    cyc++;
    if (done[act]) ndone++;
    if (!ss_n[act]) begin
      if (prev_ss) begin
        ss_low = 0; nstb = 0; nedge = 0; nsamp = 0; first_edge = -1; setup_cyc = -1;
      end
      ss_low++;
      if (strobe[act]) begin
        nstb++;
        if (setup_cyc < 0) setup_cyc = cyc;
        last_stb = cyc;
      end
      if (rise[act] || fall[act]) begin
        nedge++;
        if (first_edge < 0) first_edge = cyc;
        last_edge = cyc;
      end
      if (cpha_m ? fall[act] : rise[act]) begin
        if (nsamp < W) mlog[nsamp] = mosi[act];
        nsamp++;
      end
    end
    prev_ss = ss_n[act];
  end
  typedef struct {
    int inst; logic [1:0] md; logic [W-1:0] tx; bit lp; logic [W-1:0] sl; int p; logic [W-1:0] rx;
  } vec_t;
  vec_t v [6];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic setup_xfer(input vec_t x);
    act = x.inst; per = x.p; mode = x.md; tx_data = x.tx; loop = x.lp; slave = x.sl; cpha_m = x.md[0];
  endtask
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (done[act]) begin
        ok = 1'b1;
        return;
      end
    end
  endtask
  task automatic check_done(input vec_t x, input bit ok, input int nd);
    for (int j = 0; j < W; j++) expm[j] = x.inst == 1 ? x.tx[j] : x.tx[W-1-j];
    chk("done_seen", 32'(ok), 1);
    chk("rx_data", 32'(rx_d[act]), 32'(x.rx));
    chk("busy_at_done", 32'(busy[act]), 0);
    chk("ss_n_at_done", 32'(ss_n[act]), 1);
    chk("gen_en_at_done", 32'(gen_en[act]), 0);
    chk("sclk_en_at_done", 32'(sclk_en[act]), 0);
    chk("edge_count", 32'(nedge), 2 * W);
    chk("strobes_ss_low", 32'(nstb), 2 * W + 2);
    chk("ss_low_cycles", 32'(ss_low), 32'(x.p * (2 * W + 2)));
    chk("setup_period", 32'(first_edge - setup_cyc), 32'(x.p));
    chk("hold_period", 32'(last_stb - last_edge), 32'(x.p));
    chk("mosi_bits", 32'(mlog), 32'(expm));
    chk("done_count", 32'(ndone), 32'(nd + 1));
  endtask
  task automatic do_vec(input vec_t x);
    bit ok;
    int nd;
    setup_xfer(x);
    nd = ndone;
    start[act] = 1'b1;
    @(negedge clk); #1;
    start[act] = 1'b0;
    chk("busy_after_start", 32'(busy[act]), 1);
    chk("ss_n_after_start", 32'(ss_n[act]), 0);
    wait_done(ok);
    check_done(x, ok, nd);
    @(negedge clk); #1;
    chk("done_one_cycle", 32'(done[act]), 0);
  endtask
  initial begin
    bit ok;
    int nd;
    vec_t h;
    v[0] = '{0, 2'b00, 8'hA5, 1'b1, 8'h00, 4,  8'hA5};
    v[1] = '{0, 2'b01, 8'h3C, 1'b0, 8'hC3, 4,  8'hC3};
    v[2] = '{1, 2'b00, 8'h01, 1'b0, 8'h80, 3,  8'h80};
    v[3] = '{0, 2'b10, 8'h5A, 1'b0, 8'h96, 2,  8'h96};
    v[4] = '{1, 2'b11, 8'hC4, 1'b1, 8'h00, 5,  8'hC4};
    v[5] = '{0, 2'b00, 8'hFF, 1'b0, 8'h00, 65, 8'h00};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ss_n", 32'(ss_n), 3);
    chk("rst_gen_en", 32'(gen_en), 0);
    chk("rst_sclk_en", 32'(sclk_en), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rx0", 32'(rx_d[0]), 0);
    chk("rst_rx1", 32'(rx_d[1]), 0);
    rst = 1'b0;
    @(negedge clk); #1;
    for (int i = 0; i < 6; i++) do_vec(v[i]);
    h = '{0, 2'b00, 8'h69, 1'b1, 8'h00, 2, 8'h69};
    setup_xfer(h);
    nd = ndone;
    start[0] = 1'b1;
    @(negedge clk); #1;
    start[0] = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    start[0] = 1'b1;
    tx_data = 8'h12;
    mode = 2'b01;
    wait_done(ok);
    check_done(h, ok, nd);
    tx_data = 8'h96;
    mode = 2'b00;
    h.tx = 8'h96;
    h.rx = 8'h96;
    nd = ndone;
    @(negedge clk); #1;
    start[0] = 1'b0;
    chk("b2b_ss_n_low", 32'(ss_n[0]), 0);
    chk("b2b_busy", 32'(busy[0]), 1);
    wait_done(ok);
    check_done(h, ok, nd);
    h = '{0, 2'b00, 8'hF0, 1'b0, 8'h0F, 3, 8'h0F};
    setup_xfer(h);
    start[0] = 1'b1;
    @(negedge clk); #1;
    start[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk); #1;
      ok = nedge >= 5;
    end
    chk("reached_5_edges", 32'(ok), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ss_n", 32'(ss_n[0]), 1);
    chk("midrst_gen_en", 32'(gen_en[0]), 0);
    chk("midrst_sclk_en", 32'(sclk_en[0]), 0);
    chk("midrst_rx_data", 32'(rx_d[0]), 0);
    chk("midrst_busy", 32'(busy[0]), 0);
    chk("midrst_mosi", 32'(mosi[0]), 0);
    nd = ndone;
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (80) @(negedge clk);
    #1;
    chk("midrst_no_done", 32'(ndone), 32'(nd));
    chk("midrst_idle", 32'(busy[0]), 0);
    do_vec(v[0]);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
